// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field layout, opcodes and status flags.
package cpu_pkg;

  localparam int unsigned PC_WIDTH    = 9;
  localparam int unsigned INSTR_WIDTH = 32;

  localparam int unsigned OpALsb    = 0;
  localparam int unsigned OpAMsb    = 7;
  localparam int unsigned OpBLsb    = 8;
  localparam int unsigned OpBMsb    = 15;
  localparam int unsigned OpcodeLsb = 16;
  localparam int unsigned OpcodeMsb = 20;

  typedef enum logic [4:0] {
    OpNop      = 5'd0,
    OpAdd      = 5'd1,
    OpSub      = 5'd2,
    OpAnd      = 5'd3,
    OpOr       = 5'd4,
    OpXor      = 5'd5,
    OpMultiply = 5'd6,
    OpLoad     = 5'd7,
    OpStore    = 5'd8,
    OpJump     = 5'd9,
    OpJumpZ    = 5'd10,
    OpHalt     = 5'd31
  } opcode_e;

  localparam int unsigned SregZero     = 0;
  localparam int unsigned SregCarry    = 1;
  localparam int unsigned SregNegative = 2;
  localparam int unsigned SregOverflow = 3;

  function automatic opcode_e instr_opcode(input logic [INSTR_WIDTH-1:0] word);
    return opcode_e'(word[OpcodeMsb:OpcodeLsb]);
  endfunction

  // Words held or owed to the fetch buffer once this cycle's accept is taken out.
  function automatic logic [1:0] fetch_occupancy(input logic d_valid, input logic s_valid,
                                                 input logic inflight, input logic accept);
    return 2'(d_valid) + 2'(s_valid) + 2'(inflight) - 2'(accept);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one skid entry; keeps order and holds the presented word stable on hold.
module fetch_skid_buf #(
  parameter int unsigned Width = 41
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             hold_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  output logic             skid_valid_o
);

  logic             d_valid_q, d_valid_d;
  logic [Width-1:0] d_data_q, d_data_d;
  logic             s_valid_q, s_valid_d;
  logic [Width-1:0] s_data_q, s_data_d;
  logic             d_free;

  assign d_free = ~d_valid_q | ~hold_i;

  always_comb begin
    d_valid_d = d_valid_q;
    d_data_d  = d_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush_i) begin
      d_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (d_free) begin
      if (s_valid_q) begin
        d_valid_d = 1'b1;
        d_data_d  = s_data_q;
        s_valid_d = in_valid_i;
        if (in_valid_i) s_data_d = in_data_i;
      end else begin
        d_valid_d = in_valid_i;
        if (in_valid_i) d_data_d = in_data_i;
      end
    end else if (in_valid_i) begin
      // Issue logic guarantees the skid is empty whenever a word lands behind a held one.
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

  assign out_valid_o  = d_valid_q;
  assign out_data_o   = d_data_q;
  assign skid_valid_o = s_valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency ROM reads and hands words to the
// control unit with valid/hold flow control; jumps redirect and flush wrong-path words.
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int unsigned         INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   hold,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_line_num
);

  import cpu_pkg::*;

  localparam int unsigned EntryWidth = PC_WIDTH + INSTR_WIDTH;

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  inflight_q;
  logic                  issue;
  logic                  out_valid, skid_valid, accept, ret_valid;
  logic [EntryWidth-1:0] ret_entry, out_entry;

  assign accept    = out_valid & ~hold;
  assign ret_valid = inflight_q & ~jump_en;
  // pc_q has already moved one past the read that is returning now.
  assign ret_entry = {pc_q - PC_WIDTH'(1), imem_rdata};

  always_comb begin
    issue     = 1'b0;
    imem_addr = pc_q;
    pc_d      = pc_q;
    if (jump_en) begin
      issue     = 1'b1;
      imem_addr = jump_line_num;
      pc_d      = jump_line_num + PC_WIDTH'(1);
    end else if (fetch_occupancy(out_valid, skid_valid, inflight_q, accept) < 2'd2) begin
      issue = 1'b1;
      pc_d  = pc_q + PC_WIDTH'(1);
    end
    imem_en = issue & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_en;
    end
  end

  fetch_skid_buf #(
    .Width (EntryWidth)
  ) u_skid (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (jump_en),
    .in_valid_i   (ret_valid),
    .in_data_i    (ret_entry),
    .hold_i       (hold),
    .out_valid_o  (out_valid),
    .out_data_o   (out_entry),
    .skid_valid_o (skid_valid)
  );

  assign instr_valid = out_valid;
  assign instr       = out_entry[INSTR_WIDTH-1:0];
  assign instr_pc    = out_entry[EntryWidth-1:INSTR_WIDTH];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random hold/jump traffic against a stream model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [8:0]  instr_pc;
  logic        instr_valid;
  logic        hold;
  logic        jump_en;
  logic [8:0]  jump_line_num;

  logic [31:0] rom [512];
  int          n_cmp;
  int          n_err;
  int          since;
  logic [8:0]  exp_pc;

  instr_fetch_unit #(
    .PC_WIDTH    (9),
    .INSTR_WIDTH (32),
    .RESET_PC    (9'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .hold          (hold),
    .jump_en       (jump_en),
    .jump_line_num (jump_line_num)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM; returns junk when not read so a wrongly sampled word is visible.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom[imem_addr];
    else         imem_rdata <= $urandom();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
  endtask

  // One clock cycle, entered and left at the falling edge. Model: after a redirect (reset
  // release or jump) words appear from the 2nd cycle on, one per cycle, ascending from the target.
  task automatic tick(input logic h, input logic j, input logic [8:0] tgt, input logic no_issue);
    hold          = h;
    jump_en       = j;
    jump_line_num = tgt;
    #1;
    chk("valid", 32'(instr_valid), 32'(since >= 2));
    if (since >= 2) begin
      chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
      chk("instr", instr, rom[exp_pc]);
    end
    if (j) begin
      chk("jump_en_issue", 32'(imem_en), 32'd1);
      chk("jump_addr", 32'(imem_addr), 32'(tgt));
    end else if (!h) begin
      chk("issue", 32'(imem_en), 32'd1);
    end
    if (no_issue) chk("hold_no_issue", 32'(imem_en), 32'd0);
    @(posedge clk);
    if (j) begin
      exp_pc = tgt;
      since  = 1;
    end else begin
      if (since >= 2 && !h) exp_pc = exp_pc + 9'd1;
      since++;
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 512; i++) rom[i] = 32'hA000_0000 + i;
    rst_n = 1'b0;
    hold = 1'b0;
    jump_en = 1'b0;
    jump_line_num = '0;
    since = 0;
    exp_pc = '0;
    repeat (3) @(negedge clk);
    chk_reset();

    // Reset release and streaming from pc 0.
    rst_n = 1'b1;
    repeat (7) tick(1'b0, 1'b0, 9'd0, 1'b0);
    chk("t2_at_pc5", 32'(exp_pc), 32'd5);

    // Hold at pc 5: no further reads, word stable, then resume in order.
    repeat (4) tick(1'b1, 1'b0, 9'd0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 9'd0, 1'b0);

    // Jump away while 10/11 are in the pipe.
    for (int k = 0; k < 20 && exp_pc != 9'd10; k++) tick(1'b0, 1'b0, 9'd0, 1'b0);
    tick(1'b0, 1'b1, 9'h040, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 9'd0, 1'b0);

    // Jump near the top of the address space: wraps to 0.
    tick(1'b0, 1'b1, 9'h1FE, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 9'd0, 1'b0);

    // Jump together with hold while pc 20 is presented.
    tick(1'b0, 1'b1, 9'h010, 1'b0);
    for (int k = 0; k < 20 && exp_pc != 9'd20; k++) tick(1'b0, 1'b0, 9'd0, 1'b0);
    chk("t5_valid_pc20", 32'(instr_valid && instr_pc == 9'd20), 32'd1);
    tick(1'b1, 1'b1, 9'h0AB, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 9'd0, 1'b0);

    // Reset pulse with a read in flight; stale rdata must not surface.
    repeat (3) tick(1'b0, 1'b0, 9'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset();
    #1;
    rst_n  = 1'b1;
    since  = 0;
    exp_pc = '0;
    repeat (5) tick(1'b0, 1'b0, 9'd0, 1'b0);

    // Random hold/jump traffic.
    for (int k = 0; k < 400; k++) begin
      logic       rh, rj;
      logic [8:0] rt;
      rh = ($urandom_range(0, 9) < 3);
      rj = ($urandom_range(0, 19) == 0);
      rt = 9'($urandom_range(0, 511));
      tick(rh, rj, rt, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
